layer_address_generator: RTL and testbench
==========================================

Name: layer_address_generator

Overview:
- Sequences all memory addresses for one fully-connected layer of the neural accelerator datapath.
- It latches a layer-size instruction word (Nk) on a read strobe and tracks current and previous layer sizes.
- It then walks every (neuron, input) pair, driving neuron-RAM read, weight-ROM read and neuron-RAM write addresses, with per-neuron and per-layer completion pulses.
- It sits between the instruction memory/control unit and the weight ROM, neuron RAM and MAC core.

Parameters:
- AW, 8, width of all addresses and of layer sizes.
- END_OF_PROGRAM, 8'hFF, Nk value that halts the generator.
- BIAS_ADDR, 8'd255, neuron-RAM cell holding constant 1; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- read  input  1  strobe: latch Nk and start the next layer.
- Nk  input  AW  instruction word: next layer size, or END_OF_PROGRAM.
- read_weight_base_addr  input  AW  first weight address of the layer; sampled on read.
- read_neuro_base_addr  input  AW  base of the input activations; sampled on read.
- write_neuro_base_addr  input  AW  base of the output activations; sampled on read.
- neuro_read_addr  output  AW  neuron-RAM read address.
- weight_read_addr  output  AW  weight-ROM read address.
- neuro_write_addr  output  AW  neuron-RAM write address of the current neuron.
- neuron_finished  output  1  high on the last MAC cycle of each neuron.
- finished  output  1  one-cycle pulse after the last neuron of a layer completes.
- current_layer_size  output  AW  latched Nk.
- previous_layer_size  output  AW  previous latched Nk.

Behaviour:
- States: IDLE, RUN, FINISH, HALT. reset low forces IDLE, zeroes all registers and holds every output at 0.
- IDLE, read=1, on the clock edge:
  - previous_layer_size <= current_layer_size; current_layer_size <= Nk.
  - Address registers load the three bases; counters i and j clear.
- IDLE next state after that edge:
  - Nk==END_OF_PROGRAM -> HALT.
  - Old current_layer_size==0 (first, input-layer instruction) -> IDLE; no pulses.
  - Nk==0 -> FINISH.
  - Otherwise -> RUN.
- RUN, every cycle:
  - Outputs are the registered values: neuro_read_addr=read_base+i, weight_read_addr=weight_base+j*prev+i (running counter), neuro_write_addr=write_base+j.
  - neuron_finished is combinational = (state==RUN && i==prev-1).
  - On the edge, weight counter +1 except on the final MAC of the layer, where it holds.
  - i wraps to 0 and j increments when i==prev-1.
  - At i==prev-1 && j==curr-1 -> FINISH.
- FINISH: finished=1 for exactly one cycle. weight_read_addr equals the last weight used, so the top forms the next base as +1. Next state IDLE.
- HALT: all registers are held and read is ignored until reset.
- read in RUN or FINISH is ignored.
- Arithmetic is AW-bit unsigned and wraps modulo 2^AW; there is no overflow flag.
- Latency: the first MAC address is valid the cycle after read; the layer occupies prev*curr RUN cycles plus 1 FINISH cycle.
- Reset asserted mid-RUN aborts immediately; no finished pulse is emitted.

Optional Feature:
- Macro: LAYER_ADDRGEN_BIAS_EN.
- When defined: each neuron gets one extra MAC cycle after its prev inputs. In that cycle neuro_read_addr=BIAS_ADDR, the weight counter advances, and neuron_finished moves to this cycle. The layer takes (prev+1)*curr RUN cycles.
- When undefined: no bias cycle, and BIAS_ADDR is unused.

Decomposition:
- Shared package: state enum (IDLE/RUN/FINISH/HALT), AW, END_OF_PROGRAM.
- One sub-module, addrgen_loop_counter: a loadable AW-bit counter with terminal-count compare. Instantiate it twice (i against prev-1, j against curr-1).

Test Plan:
- Setup for the first three scenarios: bases read=0, write=20, weight=0.
- Startup: read with Nk=3 -> current=3, previous=0, state stays IDLE, no neuron_finished or finished.
- Layer run: then read with Nk=2 ->
  - previous=3, current=2; 6 RUN cycles.
  - neuro_read_addr 0,1,2,0,1,2; weight_read_addr 0..5.
  - neuron_finished on cycles 3 and 6 with neuro_write_addr 20 then 21.
  - finished pulse on cycle 7 with weight_read_addr=5.
- End of program: read with Nk=8'hFF -> current=255, previous=2, HALT. Later reads change nothing; reset low returns all outputs to 0.
- Address wrap: read_base=254, prev=3, curr=1 -> neuro_read_addr 254,255,0, then neuron_finished, then finished.
- Reset mid-layer: drop reset during RUN cycle 2 -> outputs 0 asynchronously, no finished. After release, an Nk=4 read behaves as a first instruction.
- Bias (with LAYER_ADDRGEN_BIAS_EN): prev=2, curr=1 -> neuro_read_addr 0,1,255; weights 0,1,2; neuron_finished on cycle 3.

Source files
------------

// File: rtl/layer_address_generator_pkg.sv
// Shared types and constants for the fully-connected layer address generator.
package layer_address_generator_pkg;

    localparam int unsigned LAG_AW = 8;
    localparam logic [LAG_AW-1:0] LAG_END_OF_PROGRAM = 8'hFF;
    localparam logic [LAG_AW-1:0] LAG_BIAS_ADDR = 8'd255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/layer_address_generator_loop_counter.sv
// Loadable up-counter with terminal-count compare; wraps to zero when stepped at terminal count.
module addrgen_loop_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q, count_d;

    assign count_o = count_q;
    assign tc_o    = (count_q == tc_val_i);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = tc_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/layer_address_generator.sv
// Walks every (neuron, input) pair of one FC layer, driving neuron-RAM and weight-ROM addresses.
// Optional per-neuron bias cycle enabled by defining LAYER_ADDRGEN_BIAS_EN.
//
// state  | meaning
// IDLE   | waiting for a read strobe carrying the next layer size
// RUN    | one MAC per cycle over prev inputs (plus bias) for each of curr neurons
// FINISH | one-cycle layer-complete pulse
// HALT   | end of program reached; frozen until reset
module layer_address_generator
    import layer_address_generator_pkg::*;
#(
    parameter int unsigned      AW             = LAG_AW,
    parameter logic [AW-1:0]    END_OF_PROGRAM = LAG_END_OF_PROGRAM
`ifdef LAYER_ADDRGEN_BIAS_EN
    , parameter logic [AW-1:0]  BIAS_ADDR      = LAG_BIAS_ADDR
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          read,
    input  logic [AW-1:0] Nk,
    input  logic [AW-1:0] read_weight_base_addr,
    input  logic [AW-1:0] read_neuro_base_addr,
    input  logic [AW-1:0] write_neuro_base_addr,
    output logic [AW-1:0] neuro_read_addr,
    output logic [AW-1:0] weight_read_addr,
    output logic [AW-1:0] neuro_write_addr,
    output logic          neuron_finished,
    output logic          finished,
    output logic [AW-1:0] current_layer_size,
    output logic [AW-1:0] previous_layer_size
);

    state_t        state_q, state_d;
    logic [AW-1:0] curr_q, curr_d;
    logic [AW-1:0] prev_q, prev_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] wt_q, wt_d;

    logic [AW-1:0] i_cnt, j_cnt, i_tc_val;
    logic          i_tc, j_tc;
    logic          start, in_run, last_mac;

    assign start    = (state_q == IDLE) && read;
    assign in_run   = (state_q == RUN);
    assign last_mac = in_run && i_tc && j_tc;

`ifdef LAYER_ADDRGEN_BIAS_EN
    // Input index runs one past the last activation to make room for the bias term.
    assign i_tc_val = prev_q;
`else
    assign i_tc_val = prev_q - AW'(1);
`endif

    addrgen_loop_counter #(.W(AW)) u_i_cnt (
        .clk_i    (clk),
        .rst_n_i  (reset),
        .clr_i    (start),
        .inc_i    (in_run && !last_mac),
        .tc_val_i (i_tc_val),
        .count_o  (i_cnt),
        .tc_o     (i_tc)
    );

    addrgen_loop_counter #(.W(AW)) u_j_cnt (
        .clk_i    (clk),
        .rst_n_i  (reset),
        .clr_i    (start),
        .inc_i    (in_run && i_tc && !j_tc),
        .tc_val_i (curr_q - AW'(1)),
        .count_o  (j_cnt),
        .tc_o     (j_tc)
    );

    always_comb begin
        state_d   = state_q;
        curr_d    = curr_q;
        prev_d    = prev_q;
        rd_base_d = rd_base_q;
        wr_base_d = wr_base_q;
        wt_d      = wt_q;
        case (state_q)
            IDLE: begin
                if (read) begin
                    prev_d    = curr_q;
                    curr_d    = Nk;
                    rd_base_d = read_neuro_base_addr;
                    wr_base_d = write_neuro_base_addr;
                    wt_d      = read_weight_base_addr;
                    if (Nk == END_OF_PROGRAM) begin
                        state_d = HALT;
                    end else if (curr_q == '0) begin
                        state_d = IDLE;
                    end else if (Nk == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Weight counter parks on the last weight so the next layer base is this +1.
                if (last_mac) begin
                    state_d = FINISH;
                end else begin
                    wt_d = wt_q + AW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            curr_q    <= '0;
            prev_q    <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            wt_q      <= '0;
        end else begin
            state_q   <= state_d;
            curr_q    <= curr_d;
            prev_q    <= prev_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
            wt_q      <= wt_d;
        end
    end

`ifdef LAYER_ADDRGEN_BIAS_EN
    assign neuro_read_addr = (in_run && i_tc) ? BIAS_ADDR : rd_base_q + i_cnt;
`else
    assign neuro_read_addr = rd_base_q + i_cnt;
`endif
    assign weight_read_addr    = wt_q;
    assign neuro_write_addr    = wr_base_q + j_cnt;
    assign neuron_finished     = in_run && i_tc;
    assign finished            = (state_q == FINISH);
    assign current_layer_size  = curr_q;
    assign previous_layer_size = prev_q;

endmodule

// File: tb/tb_layer_address_generator.sv
// Directed self-checking bench for layer_address_generator.
module tb_layer_address_generator;

    logic       clk;
    logic       reset;
    logic       read;
    logic [7:0] Nk;
    logic [7:0] read_weight_base_addr;
    logic [7:0] read_neuro_base_addr;
    logic [7:0] write_neuro_base_addr;
    logic [7:0] neuro_read_addr;
    logic [7:0] weight_read_addr;
    logic [7:0] neuro_write_addr;
    logic       neuron_finished;
    logic       finished;
    logic [7:0] current_layer_size;
    logic [7:0] previous_layer_size;

    int total = 0;
    int bad   = 0;

    layer_address_generator dut (
        .clk                   (clk),
        .reset                 (reset),
        .read                  (read),
        .Nk                    (Nk),
        .read_weight_base_addr (read_weight_base_addr),
        .read_neuro_base_addr  (read_neuro_base_addr),
        .write_neuro_base_addr (write_neuro_base_addr),
        .neuro_read_addr       (neuro_read_addr),
        .weight_read_addr      (weight_read_addr),
        .neuro_write_addr      (neuro_write_addr),
        .neuron_finished       (neuron_finished),
        .finished              (finished),
        .current_layer_size    (current_layer_size),
        .previous_layer_size   (previous_layer_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Presents one instruction for one clock edge; returns at the negedge after the latching edge.
    task automatic do_read(input logic [7:0] nk, input logic [7:0] rb, input logic [7:0] wb,
                           input logic [7:0] wtb);
        @(negedge clk);
        Nk = nk;
        read_neuro_base_addr = rb;
        write_neuro_base_addr = wb;
        read_weight_base_addr = wtb;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        total++;
        if ({neuro_read_addr, weight_read_addr, neuro_write_addr, neuron_finished, finished,
             current_layer_size, previous_layer_size} !== 42'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {neuro_read_addr, weight_read_addr,
                     neuro_write_addr, neuron_finished, finished, current_layer_size, previous_layer_size});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_startup();
        do_read(8'd3, 8'd0, 8'd20, 8'd0);
        total++;
        if ({current_layer_size, previous_layer_size, neuron_finished, finished} !== {8'd3, 8'd0, 2'b00}) begin
            bad++;
            $display("FAIL startup_sizes got=%h want=%h",
                     {current_layer_size, previous_layer_size, neuron_finished, finished}, {8'd3, 8'd0, 2'b00});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({neuro_read_addr, neuron_finished, finished} !== {8'd0, 2'b00}) begin
                bad++;
                $display("FAIL startup_idle cyc=%0d got=%h want=%h", c,
                         {neuro_read_addr, neuron_finished, finished}, {8'd0, 2'b00});
            end
        end
    endtask

    task automatic test_layer_run();
        int exp_nra [6] = '{0, 1, 2, 0, 1, 2};
        int exp_nwa [6] = '{20, 20, 20, 21, 21, 21};
        int exp_nf  [6] = '{0, 0, 1, 0, 0, 1};
        do_read(8'd2, 8'd0, 8'd20, 8'd0);
        total++;
        if ({current_layer_size, previous_layer_size} !== {8'd2, 8'd3}) begin
            bad++;
            $display("FAIL layer_sizes got=%h want=%h", {current_layer_size, previous_layer_size}, {8'd2, 8'd3});
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if ({neuro_read_addr, weight_read_addr, neuro_write_addr, neuron_finished, finished} !==
                {8'(exp_nra[c]), 8'(c), 8'(exp_nwa[c]), 1'(exp_nf[c]), 1'b0}) begin
                bad++;
                $display("FAIL layer_run cyc=%0d got=%h want=%h", c + 1,
                         {neuro_read_addr, weight_read_addr, neuro_write_addr, neuron_finished, finished},
                         {8'(exp_nra[c]), 8'(c), 8'(exp_nwa[c]), 1'(exp_nf[c]), 1'b0});
            end
            @(negedge clk);
        end
        total++;
        if ({finished, neuron_finished, weight_read_addr} !== {2'b10, 8'd5}) begin
            bad++;
            $display("FAIL layer_finish got=%h want=%h", {finished, neuron_finished, weight_read_addr}, {2'b10, 8'd5});
        end
        @(negedge clk);
        total++;
        if (finished !== 1'b0) begin
            bad++;
            $display("FAIL layer_finish_width got=%b want=0", finished);
        end
    endtask

    task automatic test_end_of_program();
        do_read(8'hFF, 8'd0, 8'd20, 8'd0);
        total++;
        if ({current_layer_size, previous_layer_size, neuron_finished, finished} !== {8'd255, 8'd2, 2'b00}) begin
            bad++;
            $display("FAIL eop_sizes got=%h want=%h",
                     {current_layer_size, previous_layer_size, neuron_finished, finished}, {8'd255, 8'd2, 2'b00});
        end
        do_read(8'd5, 8'd9, 8'd9, 8'd9);
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({current_layer_size, previous_layer_size, neuro_read_addr, weight_read_addr, neuro_write_addr,
                 neuron_finished, finished} !== {8'd255, 8'd2, 8'd0, 8'd0, 8'd20, 2'b00}) begin
                bad++;
                $display("FAIL eop_halt cyc=%0d got=%h want=%h", c,
                         {current_layer_size, previous_layer_size, neuro_read_addr, weight_read_addr,
                          neuro_write_addr, neuron_finished, finished},
                         {8'd255, 8'd2, 8'd0, 8'd0, 8'd20, 2'b00});
            end
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({neuro_read_addr, weight_read_addr, neuro_write_addr, neuron_finished, finished,
             current_layer_size, previous_layer_size} !== 42'd0) begin
            bad++;
            $display("FAIL eop_reset got=%h want=0", {neuro_read_addr, weight_read_addr, neuro_write_addr,
                     neuron_finished, finished, current_layer_size, previous_layer_size});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_addr_wrap();
        int exp_nra [3] = '{254, 255, 0};
        int exp_nf  [3] = '{0, 0, 1};
        do_read(8'd3, 8'd0, 8'd20, 8'd0);
        do_read(8'd1, 8'd254, 8'd20, 8'd0);
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({neuro_read_addr, weight_read_addr, neuron_finished, finished} !==
                {8'(exp_nra[c]), 8'(c), 1'(exp_nf[c]), 1'b0}) begin
                bad++;
                $display("FAIL wrap cyc=%0d got=%h want=%h", c + 1,
                         {neuro_read_addr, weight_read_addr, neuron_finished, finished},
                         {8'(exp_nra[c]), 8'(c), 1'(exp_nf[c]), 1'b0});
            end
            @(negedge clk);
        end
        total++;
        if ({finished, weight_read_addr} !== {1'b1, 8'd2}) begin
            bad++;
            $display("FAIL wrap_finish got=%h want=%h", {finished, weight_read_addr}, {1'b1, 8'd2});
        end
    endtask

    task automatic test_reset_mid_layer();
        pulse_reset();
        do_read(8'd1, 8'd0, 8'd0, 8'd0);
        do_read(8'd3, 8'd10, 8'd30, 8'd40);
        total++;
        if ({neuro_read_addr, weight_read_addr} !== {8'd10, 8'd40}) begin
            bad++;
            $display("FAIL mid_cyc1 got=%h want=%h", {neuro_read_addr, weight_read_addr}, {8'd10, 8'd40});
        end
        @(negedge clk);
        total++;
        if (weight_read_addr !== 8'd41) begin
            bad++;
            $display("FAIL mid_cyc2 got=%h want=%h", weight_read_addr, 8'd41);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({neuro_read_addr, weight_read_addr, neuro_write_addr, neuron_finished, finished,
             current_layer_size, previous_layer_size} !== 42'd0) begin
            bad++;
            $display("FAIL mid_async_reset got=%h want=0", {neuro_read_addr, weight_read_addr, neuro_write_addr,
                     neuron_finished, finished, current_layer_size, previous_layer_size});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (finished !== 1'b0) begin
                bad++;
                $display("FAIL mid_no_finish cyc=%0d got=%b want=0", c, finished);
            end
        end
        reset = 1'b1;
        do_read(8'd4, 8'd5, 8'd6, 8'd7);
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({current_layer_size, previous_layer_size, neuro_read_addr, weight_read_addr, neuro_write_addr,
                 neuron_finished, finished} !== {8'd4, 8'd0, 8'd5, 8'd7, 8'd6, 2'b00}) begin
                bad++;
                $display("FAIL mid_first_instr cyc=%0d got=%h want=%h", c,
                         {current_layer_size, previous_layer_size, neuro_read_addr, weight_read_addr,
                          neuro_write_addr, neuron_finished, finished},
                         {8'd4, 8'd0, 8'd5, 8'd7, 8'd6, 2'b00});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_layer();
        do_read(8'd0, 8'd0, 8'd0, 8'd0);
        total++;
        if ({finished, neuron_finished, current_layer_size, previous_layer_size} !== {2'b10, 8'd0, 8'd4}) begin
            bad++;
            $display("FAIL zero_layer got=%h want=%h",
                     {finished, neuron_finished, current_layer_size, previous_layer_size}, {2'b10, 8'd0, 8'd4});
        end
        @(negedge clk);
        total++;
        if (finished !== 1'b0) begin
            bad++;
            $display("FAIL zero_layer_width got=%b want=0", finished);
        end
    endtask

`ifdef LAYER_ADDRGEN_BIAS_EN
    task automatic test_bias();
        int exp_nra [3] = '{0, 1, 255};
        int exp_nf  [3] = '{0, 0, 1};
        pulse_reset();
        do_read(8'd2, 8'd0, 8'd0, 8'd0);
        do_read(8'd1, 8'd0, 8'd0, 8'd0);
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({neuro_read_addr, weight_read_addr, neuron_finished, finished} !==
                {8'(exp_nra[c]), 8'(c), 1'(exp_nf[c]), 1'b0}) begin
                bad++;
                $display("FAIL bias cyc=%0d got=%h want=%h", c + 1,
                         {neuro_read_addr, weight_read_addr, neuron_finished, finished},
                         {8'(exp_nra[c]), 8'(c), 1'(exp_nf[c]), 1'b0});
            end
            @(negedge clk);
        end
        total++;
        if ({finished, weight_read_addr} !== {1'b1, 8'd2}) begin
            bad++;
            $display("FAIL bias_finish got=%h want=%h", {finished, weight_read_addr}, {1'b1, 8'd2});
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        read = 1'b0;
        Nk = 8'd0;
        read_weight_base_addr = 8'd0;
        read_neuro_base_addr = 8'd0;
        write_neuro_base_addr = 8'd0;
        test_reset();
        test_startup();
`ifdef LAYER_ADDRGEN_BIAS_EN
        test_bias();
`else
        test_layer_run();
        test_end_of_program();
        test_addr_wrap();
`endif
        test_reset_mid_layer();
        test_zero_layer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
